// File: rtl/pll_lock_reset_seq.sv
// Reset/lock sequencer for the PLLVR: pulses the PLL reset, qualifies lock, then releases sys_rst and ready.
// Optional build macro PLL_LOCK_LOSS_CNT_EN adds a saturating lock-loss counter.
module pll_lock_reset_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 2500,
  parameter int STABLE_CYCLES = 250,
  parameter int PWRUP_CYCLES  = 3750,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lock,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       ready,
  output logic [2:0] state,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    PWRUP     = 3'd3,
    RUN       = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWRUP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             lock_meta_q, lock_s_q;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;

  // lock comes from the PLL analog block; only lock_s_q is seen by the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      retry_q     <= 4'd0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // A lock arriving on the timeout cycle still counts as a lock.
        if (lock_s_q) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RST;
          if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
        end
      end
      STABLE: begin
        if (!lock_s_q) state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = PWRUP;
      end
      PWRUP: begin
        if (!lock_s_q) state_d = PLL_RST;
        else if (cnt_q == PWRUP_LAST) state_d = RUN;
      end
      RUN: begin
        if (!lock_s_q) state_d = PLL_RST;
      end
      default: state_d = PLL_RST;
    endcase
    if (state_d != state_q) cnt_d = '0;
    // Outputs follow the next state so they move on the same edge as state.
    pll_reset_d = (state_d == PLL_RST);
    sys_rst_d   = (state_d == PLL_RST) || (state_d == WAIT_LOCK) || (state_d == STABLE);
    ready_d     = (state_d == RUN);
  end

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0] loss_q;
  logic       loss_evt;

  assign loss_evt = ((state_q == PWRUP) || (state_q == RUN)) && !lock_s_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      loss_q <= 8'd0;
    end else if (loss_evt && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

  assign pll_reset = pll_reset_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule
